// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants for the VGA raster path: the default 1024x768 @ 64 MHz mode,
// sync polarity encoding, and the x/y counter widths that the pixel/VRAM stage
// also uses to size its beam-position inputs.
// No ports (package).
// -----------------------------------------------------------------------------
package vga_pkg;

   // Beam position widths, shared with the downstream pixel stage.
   localparam int unsigned X_W = 11;
   localparam int unsigned Y_W = 10;

   // Sync polarity encoding: the parameter value is the active level.
   localparam bit SYNC_ACTIVE_LOW  = 1'b0;
   localparam bit SYNC_ACTIVE_HIGH = 1'b1;

   // Default mode: 1024x768, 64 MHz pixel clock, ~59 Hz frame rate.
   localparam int unsigned DEF_H_VISIBLE = 1024;
   localparam int unsigned DEF_H_FRONT   = 24;
   localparam int unsigned DEF_H_SYNC    = 136;
   localparam int unsigned DEF_H_BACK    = 160;
   localparam int unsigned DEF_V_VISIBLE = 768;
   localparam int unsigned DEF_V_FRONT   = 3;
   localparam int unsigned DEF_V_SYNC    = 6;
   localparam int unsigned DEF_V_BACK    = 29;

   // Drive level of a sync line given its polarity and whether it is in its pulse.
   function automatic logic sync_level(input bit pol, input bit active);
      return active ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis (horizontal or vertical). Counts 0..TOTAL-1 on each i_step
// and derives the registered sync and active flags for that axis. The flags are
// computed from the next count so they line up with o_count in the same cycle.
//
// Ports:
//   i_clk     clock
//   i_rst_n   synchronous active-low reset
//   i_step    advance the counter this cycle
//   o_count   current position on this axis
//   o_wrap    high in the cycle that i_step takes the count from TOTAL-1 to 0
//   o_sync    sync output at the configured polarity
//   o_active  high while the position is inside the visible region
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_pkg::*;
#(
   parameter int unsigned VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned FRONT   = DEF_H_FRONT,
   parameter int unsigned SYNC    = DEF_H_SYNC,
   parameter int unsigned BACK    = DEF_H_BACK,
   parameter bit          POL     = SYNC_ACTIVE_LOW,
   parameter int unsigned W       = X_W
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_step,
   output logic [W-1:0] o_count,
   output logic         o_wrap,
   output logic         o_sync,
   output logic         o_active
);

   localparam int unsigned TOTAL      = VISIBLE + FRONT + SYNC + BACK;
   localparam int unsigned SYNC_START = VISIBLE + FRONT;
   localparam int unsigned SYNC_END   = SYNC_START + SYNC;

   if (TOTAL > (1 << W)) begin : g_width_check
      $error("vga_axis_counter: TOTAL does not fit in W bits");
   end

   logic [W-1:0] r_count;
   logic [W-1:0] w_count_next;
   logic [31:0]  w_next_ext;
   logic         w_at_end;
   logic         w_in_sync;
   logic         r_sync;
   logic         r_active;

   assign w_at_end = (r_count == W'(TOTAL - 1));
   assign o_wrap   = i_step & w_at_end;

   always_comb begin
      w_count_next = r_count;
      if (i_step) begin
         w_count_next = w_at_end ? '0 : r_count + 1'b1;
      end
   end

   // Compare in 32 bits so SYNC_END == 2**W cannot truncate to zero.
   assign w_next_ext = 32'(w_count_next);
   assign w_in_sync  = (w_next_ext >= SYNC_START) && (w_next_ext < SYNC_END);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count  <= '0;
         r_sync   <= sync_level(POL, 1'b0);
         r_active <= 1'b1;
      end else begin
         r_count  <= w_count_next;
         r_sync   <= sync_level(POL, w_in_sync);
         r_active <= (w_next_ext < VISIBLE);
      end
   end

   assign o_count  = r_count;
   assign o_sync   = r_sync;
   assign o_active = r_active;

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Raster timing generator feeding the VGA pixel/VRAM stage. Produces the beam
// position, h/v sync, blanking, a one-clock retrace strobe per scanline (at
// hsync start) and a sticky interrupt raised at hblank and/or vblank entry.
//
// Ports:
//   i_clk                         clock, nominally 64 MHz
//   i_rst_n                       synchronous active-low reset
//   i_cli                         clear the pending interrupt
//   i_enable_interrupt_on_hblank  raise interrupt at hblank entry of visible lines
//   i_enable_interrupt_on_vblank  raise interrupt at the first vblank line
//   o_x                           horizontal position, 0..H_TOTAL-1
//   o_y                           vertical position, 0..V_TOTAL-1
//   o_hsync                       horizontal sync, H_SYNC_POL is the active level
//   o_vsync                       vertical sync, V_SYNC_POL is the active level
//   o_retrace                     one-clock strobe per line at hsync start
//   o_blank                       high outside the visible area
//   o_interrupt                   sticky interrupt request
// -----------------------------------------------------------------------------
module vga_sync_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_VISIBLE  = DEF_H_VISIBLE,
   parameter int unsigned H_FRONT    = DEF_H_FRONT,
   parameter int unsigned H_SYNC     = DEF_H_SYNC,
   parameter int unsigned H_BACK     = DEF_H_BACK,
   parameter int unsigned V_VISIBLE  = DEF_V_VISIBLE,
   parameter int unsigned V_FRONT    = DEF_V_FRONT,
   parameter int unsigned V_SYNC     = DEF_V_SYNC,
   parameter int unsigned V_BACK     = DEF_V_BACK,
   parameter bit          H_SYNC_POL = SYNC_ACTIVE_LOW,
   parameter bit          V_SYNC_POL = SYNC_ACTIVE_LOW
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_cli,
   input  logic           i_enable_interrupt_on_hblank,
   input  logic           i_enable_interrupt_on_vblank,
   output logic [X_W-1:0] o_x,
   output logic [Y_W-1:0] o_y,
   output logic           o_hsync,
   output logic           o_vsync,
   output logic           o_retrace,
   output logic           o_blank,
   output logic           o_interrupt
);

   localparam int unsigned H_TOTAL      = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL      = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;

   if (H_TOTAL > (1 << X_W)) begin : g_h_total_check
      $error("vga_sync_gen: H_TOTAL exceeds the x counter width");
   end
   if (V_TOTAL > (1 << Y_W)) begin : g_v_total_check
      $error("vga_sync_gen: V_TOTAL exceeds the y counter width");
   end
   if (H_SYNC_START == 0) begin : g_h_sync_start_check
      $error("vga_sync_gen: hsync must not start at x = 0");
   end

   logic [X_W-1:0] w_x;
   logic [Y_W-1:0] w_y;
   logic           w_h_wrap;
   logic           w_h_sync;
   logic           w_h_active;
   logic           w_v_sync;
   logic           w_v_active;
   logic           w_unused_v_wrap;
   logic           w_pre_retrace;
   logic           w_hblank_entry;
   logic           w_vblank_entry;
   logic           w_irq_set;
   logic           r_retrace;
   logic           r_interrupt;

   vga_axis_counter #(
      .VISIBLE (H_VISIBLE),
      .FRONT   (H_FRONT),
      .SYNC    (H_SYNC),
      .BACK    (H_BACK),
      .POL     (H_SYNC_POL),
      .W       (X_W)
   ) u_h_counter (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_step   (1'b1),
      .o_count  (w_x),
      .o_wrap   (w_h_wrap),
      .o_sync   (w_h_sync),
      .o_active (w_h_active)
   );

   // The vertical axis steps once per line, on the horizontal wrap, so vsync
   // changes only at line boundaries.
   vga_axis_counter #(
      .VISIBLE (V_VISIBLE),
      .FRONT   (V_FRONT),
      .SYNC    (V_SYNC),
      .BACK    (V_BACK),
      .POL     (V_SYNC_POL),
      .W       (Y_W)
   ) u_v_counter (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_step   (w_h_wrap),
      .o_count  (w_y),
      .o_wrap   (w_unused_v_wrap),
      .o_sync   (w_v_sync),
      .o_active (w_v_active)
   );

   // Registering one position early puts the strobe on x == H_SYNC_START.
   assign w_pre_retrace  = (w_x == X_W'(H_SYNC_START - 1));

   // Set events look at the position currently on o_x/o_y.
   assign w_hblank_entry = (w_x == X_W'(H_VISIBLE)) && (w_y < Y_W'(V_VISIBLE));
   assign w_vblank_entry = (w_x == '0) && (w_y == Y_W'(V_VISIBLE));
   assign w_irq_set      = (w_hblank_entry & i_enable_interrupt_on_hblank)
                         | (w_vblank_entry & i_enable_interrupt_on_vblank);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_retrace   <= 1'b0;
         r_interrupt <= 1'b0;
      end else begin
         r_retrace <= w_pre_retrace;
         // A set event takes priority over a simultaneous clear.
         if (w_irq_set) begin
            r_interrupt <= 1'b1;
         end else if (i_cli) begin
            r_interrupt <= 1'b0;
         end
      end
   end

   assign o_x         = w_x;
   assign o_y         = w_y;
   assign o_hsync     = w_h_sync;
   assign o_vsync     = w_v_sync;
   assign o_retrace   = r_retrace;
   // Both inputs are flops in the axis counters; no path from module inputs.
   assign o_blank     = ~(w_h_active & w_v_active);
   assign o_interrupt = r_interrupt;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
// Self-checking bench. A reduced-size raster instance is compared every cycle
// against a behavioural model through a scoreboard queue; directed checks cover
// the interrupt, reset and frame-level properties. A default-mode instance is
// used for the 1024x768 hsync timing.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;
   import vga_pkg::*;

   // Reduced mode: 32 clocks per line, 20 lines per frame.
   localparam int unsigned S_HV  = 16;
   localparam int unsigned S_HF  = 4;
   localparam int unsigned S_HS  = 6;
   localparam int unsigned S_HB  = 6;
   localparam int unsigned S_HT  = S_HV + S_HF + S_HS + S_HB;
   localparam int unsigned S_VV  = 12;
   localparam int unsigned S_VF  = 2;
   localparam int unsigned S_VS  = 3;
   localparam int unsigned S_VB  = 3;
   localparam int unsigned S_VT  = S_VV + S_VF + S_VS + S_VB;
   localparam int unsigned S_HSS = S_HV + S_HF;
   localparam int unsigned S_VSS = S_VV + S_VF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic cli   = 1'b0;
   logic en_h  = 1'b0;
   logic en_v  = 1'b0;

   logic [10:0] s_x, d_x;
   logic [9:0]  s_y, d_y;
   logic        s_hs, s_vs, s_rt, s_bl, s_irq;
   logic        d_hs, d_vs, d_rt, d_bl, d_irq;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   logic [25:0] sb_q[$];

   always #5 clk = ~clk;

   vga_sync_gen #(
      .H_VISIBLE  (S_HV),
      .H_FRONT    (S_HF),
      .H_SYNC     (S_HS),
      .H_BACK     (S_HB),
      .V_VISIBLE  (S_VV),
      .V_FRONT    (S_VF),
      .V_SYNC     (S_VS),
      .V_BACK     (S_VB),
      .H_SYNC_POL (SYNC_ACTIVE_LOW),
      .V_SYNC_POL (SYNC_ACTIVE_LOW)
   ) u_dut (
      .i_clk                        (clk),
      .i_rst_n                      (rst_n),
      .i_cli                        (cli),
      .i_enable_interrupt_on_hblank (en_h),
      .i_enable_interrupt_on_vblank (en_v),
      .o_x                          (s_x),
      .o_y                          (s_y),
      .o_hsync                      (s_hs),
      .o_vsync                      (s_vs),
      .o_retrace                    (s_rt),
      .o_blank                      (s_bl),
      .o_interrupt                  (s_irq)
   );

   vga_sync_gen u_dut_def (
      .i_clk                        (clk),
      .i_rst_n                      (rst_n),
      .i_cli                        (cli),
      .i_enable_interrupt_on_hblank (en_h),
      .i_enable_interrupt_on_vblank (en_v),
      .o_x                          (d_x),
      .o_y                          (d_y),
      .o_hsync                      (d_hs),
      .o_vsync                      (d_vs),
      .o_retrace                    (d_rt),
      .o_blank                      (d_bl),
      .o_interrupt                  (d_irq)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [25:0] small_obs();
      return {s_x, s_y, s_hs, s_vs, s_rt, s_bl, s_irq};
   endfunction

   function automatic logic [25:0] def_obs();
      return {d_x, d_y, d_hs, d_vs, d_rt, d_bl, d_irq};
   endfunction

   // Advance on falling edges until the reduced DUT shows (x,y), bounded.
   task automatic wait_pos(input int unsigned x, input int unsigned y, input string tag);
      int unsigned n = 0;
      while (!(s_x == 11'(x) && s_y == 10'(y)) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({"reach_", tag}, 64'(s_x == 11'(x) && s_y == 10'(y)), 64'd1);
   endtask

   // Behavioural model of the reduced instance; expected outputs are queued at
   // each active edge and compared just after it.
   initial begin
      int unsigned mx, my;
      logic        mirq, set_ev, e_hs, e_vs, e_rt, e_bl;
      logic [25:0] exp_v;
      mx = 0;
      my = 0;
      mirq = 1'b0;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            mx = 0;
            my = 0;
            mirq = 1'b0;
         end else begin
            set_ev = (en_h && mx == S_HV && my < S_VV) || (en_v && mx == 0 && my == S_VV);
            if (set_ev) mirq = 1'b1;
            else if (cli) mirq = 1'b0;
            mx++;
            if (mx == S_HT) begin
               mx = 0;
               my++;
               if (my == S_VT) my = 0;
            end
         end
         e_hs  = !(mx >= S_HSS && mx < S_HSS + S_HS);
         e_vs  = !(my >= S_VSS && my < S_VSS + S_VS);
         e_rt  = (mx == S_HSS);
         e_bl  = (mx >= S_HV) || (my >= S_VV);
         exp_v = {11'(mx), 10'(my), e_hs, e_vs, e_rt, e_bl, mirq};
         sb_q.push_back(exp_v);
         #1;
         check("cycle", 64'(small_obs()), 64'(sb_q.pop_front()));
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned n, t0, rt_cnt, vs_cnt, bad_rt, vs_ymin, vs_ymax, hi_cnt;

      // Reset state: origin, syncs inactive (high), strobes and interrupt low.
      repeat (3) @(negedge clk);
      check("rst_small", 64'(small_obs()), 64'({11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
      check("rst_def", 64'(def_obs()), 64'({11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
      rst_n = 1'b1;

      // Default mode hsync timing.
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (d_hs !== 1'b0 && n < 3000);
      check("def_hs_start_cycle", 64'(n), 64'd1048);
      check("def_hs_start_x", 64'(d_x), 64'd1048);
      check("def_hs_start_rt_bl", 64'({d_rt, d_bl}), 64'd3);
      t0 = n;
      do begin
         @(negedge clk);
         n++;
      end while (d_hs !== 1'b1 && n < 3000);
      check("def_hs_end_x", 64'(d_x), 64'd1184);
      do begin
         @(negedge clk);
         n++;
      end while (d_hs !== 1'b0 && n < 6000);
      check("def_line_len", 64'(n - t0), 64'd1344);
      check("def_line2_y", 64'(d_y), 64'd1);

      // One full frame of the reduced mode.
      wait_pos(0, 0, "frame");
      rt_cnt  = 0;
      vs_cnt  = 0;
      bad_rt  = 0;
      vs_ymin = 1023;
      vs_ymax = 0;
      for (int i = 0; i < int'(S_HT * S_VT); i++) begin
         if (s_rt) begin
            rt_cnt++;
            if (!s_bl || s_x != 11'(S_HSS)) bad_rt++;
         end
         if (!s_vs) begin
            vs_cnt++;
            if (s_y < vs_ymin) vs_ymin = s_y;
            if (s_y > vs_ymax) vs_ymax = s_y;
         end
         @(negedge clk);
      end
      check("frame_retraces", 64'(rt_cnt), 64'(S_VT));
      check("frame_bad_retrace", 64'(bad_rt), 64'd0);
      check("frame_vs_cycles", 64'(vs_cnt), 64'(S_VS * S_HT));
      check("frame_vs_first", 64'(vs_ymin), 64'(S_VSS));
      check("frame_vs_last", 64'(vs_ymax), 64'(S_VSS + S_VS - 1));
      check("frame_wrap", 64'({s_x, s_y}), 64'd0);

      // Vblank interrupt, cleared by cli, quiet until the next frame.
      en_v = 1'b1;
      wait_pos(0, S_VV, "vbl");
      check("vbl_pre", 64'(s_irq), 64'd0);
      @(negedge clk);
      check("vbl_rise", 64'(s_irq), 64'd1);
      wait_pos(5, S_VV, "vbl_cli");
      cli = 1'b1;
      @(negedge clk);
      cli = 1'b0;
      check("vbl_cli", 64'(s_irq), 64'd0);
      hi_cnt = 0;
      n = 0;
      @(negedge clk);
      while (!(s_x == 11'd0 && s_y == 10'(S_VV)) && n < 1000) begin
         if (s_irq) hi_cnt++;
         @(negedge clk);
         n++;
      end
      check("vbl_quiet", 64'(hi_cnt), 64'd0);
      en_v = 1'b0;

      // Hblank interrupt: set wins over a simultaneous cli.
      wait_pos(S_HV, 10, "hbl");
      en_h = 1'b1;
      cli  = 1'b1;
      @(negedge clk);
      cli = 1'b0;
      check("hbl_set_wins", 64'(s_irq), 64'd1);
      wait_pos(5, S_VV, "hbl_cli");
      cli = 1'b1;
      @(negedge clk);
      cli = 1'b0;
      check("hbl_clr", 64'(s_irq), 64'd0);
      wait_pos(S_HV + 1, S_VSS, "hbl_vline");
      check("hbl_vblank_line", 64'(s_irq), 64'd0);

      // Mid-frame reset with an interrupt pending.
      wait_pos(10, 8, "mid");
      check("rst_pending", 64'(s_irq), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("mid_rst", 64'(small_obs()), 64'({11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
      check("mid_rst_def", 64'({d_x, d_y, d_hs, d_vs, d_irq}), 64'({11'd0, 10'd0, 1'b1, 1'b1, 1'b0}));
      rst_n = 1'b1;
      en_h  = 1'b0;
      @(negedge clk);
      check("post_rst", 64'({s_x, s_y}), 64'({11'd1, 10'd0}));
      repeat (5) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Raster timing generator directly upstream of the TinyQV VGA peripheral's pixel/VRAM stage.
- Produces the beam position, sync pulses, blanking, a one-cycle per-scanline retrace strobe, and a sticky CPU interrupt.
- Default mode is 1024x768 at the 64 MHz TinyQV clock (about 59 Hz frame rate).
- The consumer advances its VRAM indexing on `retrace`, gates pixels with `blank`, and forwards `interrupt` as user_interrupt.

Parameters:
- H_VISIBLE, 1024, active pixels per line
- H_FRONT, 24, horizontal front porch (clocks)
- H_SYNC, 136, hsync width (clocks)
- H_BACK, 160, horizontal back porch (clocks); H_TOTAL = 1344
- V_VISIBLE, 768, active lines
- V_FRONT, 3, vertical front porch (lines)
- V_SYNC, 6, vsync width (lines)
- V_BACK, 29, vertical back porch (lines); V_TOTAL = 806
- H_SYNC_POL, 0, active level of hsync (0 = active-low)
- V_SYNC_POL, 0, active level of vsync

Ports:
- clk  in  1  system clock, nominally 64 MHz
- rst_n  in  1  reset; synchronous, active-low
- cli  in  1  clear pending interrupt
- enable_interrupt_on_hblank  in  1  arm the interrupt at hblank entry
- enable_interrupt_on_vblank  in  1  arm the interrupt at vblank entry
- x  out  11  horizontal counter, 0..H_TOTAL-1
- y  out  10  vertical counter, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, polarity per H_SYNC_POL
- vsync  out  1  vertical sync, polarity per V_SYNC_POL
- retrace  out  1  one-clock strobe per scanline
- blank  out  1  high outside the visible area
- interrupt  out  1  sticky interrupt request

Behaviour:
- All outputs are driven from flops, with no combinational path from inputs to outputs.
  - hsync, vsync, blank and retrace are computed from the next counter values, so they are aligned with the x,y of the same cycle.
- Reset (rst_n=0 at a clk edge):
  - x=0, y=0, blank=0, retrace=0, interrupt=0.
  - hsync=~H_SYNC_POL, vsync=~V_SYNC_POL (both inactive).
  - Reset mid-frame restarts the raster at (0,0) on the next edge; a pending interrupt is lost.
- Counting:
  - x increments every clock and wraps from H_TOTAL-1 to 0.
  - On that wrap, y increments, wrapping from V_TOTAL-1 to 0.
  - The first visible pixel after reset release is (0,0).
- blank = (x >= H_VISIBLE) or (y >= V_VISIBLE).
- hsync is active iff H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC, on every line.
- vsync is active iff V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC, for whole lines (x 0..H_TOTAL-1).
- retrace is high for exactly one cycle per line, at x == H_VISIBLE+H_FRONT (hsync start).
  - It fires on all V_TOTAL lines, including vblank lines.
  - It always falls inside blank.
- Interrupt set events, evaluated on the cycle the counters show the position:
  - hblank entry: x == H_VISIBLE and y < V_VISIBLE and enable_interrupt_on_hblank.
  - vblank entry: x == 0 and y == V_VISIBLE and enable_interrupt_on_vblank.
- interrupt rises on the clock after a set event and holds until cli.
- cli=1 clears interrupt on the next edge.
  - If a set event and cli occur in the same cycle, set wins (interrupt=1).
  - Enables are sampled only at event cycles; dropping an enable does not clear a pending interrupt.
- Width rules:
  - Counters are unsigned, with no overflow beyond the TOTAL wrap.
  - x must fit 11 bits and y 10 bits; elaboration fails (generate-time check) if H_TOTAL > 2048 or V_TOTAL > 1024.

Decomposition:
- Shared package vga_pkg holds:
  - the default mode constants (1024x768 set above);
  - the sync polarity encoding (SYNC_ACTIVE_LOW=0);
  - the widths X_W=11 and Y_W=10, reused by the pixel stage.
- One sub-module, vga_axis_counter, instanced twice (h and v). Each instance:
  - is parameterised by VISIBLE/FRONT/SYNC/BACK/POL and width;
  - has inputs clk, rst_n, step;
  - has outputs count, wrap, sync, active.
- The top-level block adds blank, retrace and the interrupt logic.

Test Plan:
- Reset, then release; count cycles until the first hsync assertion → asserted at x=1048 (cycle 1048); deasserted at x=1184; line length 1344 clocks.
- Run a full frame → vsync low for y=771..776 (6 lines × 1344 clocks), frame = 806×1344 = 1,083,264 clocks, and x,y return to (0,0).
- Count retrace pulses over one frame → exactly 806 pulses, each 1 cycle wide, each at x=1048 with blank=1.
- enable_interrupt_on_vblank=1 and hblank enable 0 → interrupt rises one clock after (x=0,y=768); cli pulsed at (5,768) clears it on the next edge; no further rise until the next frame.
- enable_interrupt_on_hblank=1, with cli asserted exactly at the cycle x=1024,y=10 → interrupt=1 (set wins); no set event at x=1024,y=770 (vblank line).
- Assert rst_n=0 at (500,300) with interrupt pending → next edge x=0, y=0, interrupt=0, syncs inactive.
